tick_sched: RTL and testbench

Programmable tick-enable scheduler for the digital clock. It replaces free-running derived clocks with single-cycle enable pulses on the system clock: a seconds tick for timekeeping and a scan tick plus digit index for the 7-segment multiplexer. Divisors can be reconfigured at runtime through a valid/ready handshake; new values take effect glitch-free at the channel's next terminal count. Sits between the board clock and the timekeeping, display-scan and set/adjust logic.

---
 rtl/tick_sched_pkg.sv | 24 ++
 rtl/tick_sched_if.sv | 36 +++
 rtl/tick_sched_chan.sv | 82 ++++++++
 rtl/tick_sched.sv | 167 ++++++++++++++++
 tb/tb_tick_sched.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tick_pkg
//  Description : Shared definitions for the tick-enable scheduler: FSM state
//                encoding, minimum divisor and channel select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package tick_pkg;

    // Scheduler run state: STOP holds both channels, RUN lets them count.
    typedef enum logic [0:0] {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest divisor a channel will accept; smaller requests are raised.
    localparam int DIV_MIN = 2;

    // Values of cfg_sel.
    localparam logic CH_SEC  = 1'b0;
    localparam logic CH_SCAN = 1'b1;

endpackage : tick_pkg
`default_nettype wire

// File: rtl/tick_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : tick_sched_if
//  Description : Divisor configuration handshake for tick_sched.
//                master drives cfg_valid/cfg_sel/cfg_div, slave drives
//                cfg_ready. A transfer happens on a rising clk edge with
//                cfg_valid && cfg_ready.
//  Ports       : cfg_valid - request valid
//                cfg_ready - single config slot is free
//                cfg_sel   - 0 = seconds channel, 1 = scan channel
//                cfg_div   - requested divisor (DIV_W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tick_sched_if #(
    parameter int DIV_W = 26
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_sel;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_sel,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_sel,
        input  cfg_div,
        output cfg_ready
    );
endinterface : tick_sched_if
`default_nettype wire

// File: rtl/tick_sched_chan.sv
`default_nettype none
// ============================================================================
//  Module      : tick_chan
//  Description : One down-counting tick channel. While enabled the counter
//                decrements every cycle; at zero it reloads div-1 and raises
//                a registered one-cycle tick. A pending divisor aimed at this
//                channel is adopted at the next reload (RUN), immediately
//                (STOP) or on a sync.
//  Ports       : clk, RESET    - clock / async active-high reset
//                i_en          - count enable (scheduler in RUN)
//                i_sync        - phase restart, suppresses this cycle's tick
//                i_pend_hit    - pending config targets this channel
//                i_pend_div    - pending (already clamped) divisor
//                o_tick        - registered one-cycle tick
//                o_fire        - tick will be raised at the next edge
//                o_take        - pending divisor consumed at the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_chan #(
    parameter int DIV_W       = 26,
    parameter int DIV_DEFAULT = 50_000_000
) (
    input  wire logic             clk,
    input  wire logic             RESET,
    input  wire logic             i_en,
    input  wire logic             i_sync,
    input  wire logic             i_pend_hit,
    input  wire logic [DIV_W-1:0] i_pend_div,
    output logic                  o_tick,
    output logic                  o_fire,
    output logic                  o_take
);

    localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    logic [DIV_W-1:0] w_load_div;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_zero;
    logic             w_fire;
    logic             w_take;
    logic             w_reload;

    always_comb begin
        w_zero = (r_cnt == '0);
        // sync wins over a terminal count: reload but no tick
        w_fire = i_en && w_zero && !i_sync;
        // pending divisor lands at the terminal count in RUN, at once in STOP,
        // or on any sync
        w_take = i_pend_hit && (i_sync || !i_en || w_zero);
        w_reload   = i_sync || w_fire || w_take;
        w_load_div = w_take ? i_pend_div : r_div;
        w_cnt_nxt  = r_cnt;
        if (w_reload) begin
            w_cnt_nxt = w_load_div - c_one;
        end else if (i_en) begin
            w_cnt_nxt = r_cnt - c_one;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_div  <= c_div_rst;
            r_cnt  <= c_div_rst - c_one;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_load_div;
            r_cnt  <= w_cnt_nxt;
            r_tick <= w_fire;
        end
    end

    assign o_tick = r_tick;
    assign o_fire = w_fire;
    assign o_take = w_take;

endmodule : tick_chan
`default_nettype wire

// File: rtl/tick_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tick_sched
//  Description : Programmable tick-enable scheduler. Produces a seconds tick
//                (plus a square-wave blink level) and a display scan tick
//                with digit index, all as single-cycle enables on clk.
//                Divisors are reprogrammed through a one-entry config slot.
//  Ports       : clk        - system clock
//                RESET      - asynchronous active-high reset
//                run        - 1 = channels count, 0 = hold
//                sync_req   - restart both channel phases
//                cfg        - divisor config handshake (slave side)
//                sec_tick   - one-cycle pulse every seconds divisor cycles
//                sec_sq     - toggles with each sec_tick
//                scan_tick  - one-cycle pulse every scan divisor cycles
//                scan_idx   - current digit, advances with scan_tick
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_sched
    import tick_pkg::*;
#(
    parameter int DIV_W            = 26,
    parameter int SEC_DIV_DEFAULT  = 50_000_000,
    parameter int SCAN_DIV_DEFAULT = 250_000,
    parameter int NSCAN            = 8,
    localparam int IDX_W           = (NSCAN > 1) ? $clog2(NSCAN) : 1
) (
    input  wire logic       clk,
    input  wire logic       RESET,
    input  wire logic       run,
    input  wire logic       sync_req,
    tick_sched_if.slave     cfg,
    output logic            sec_tick,
    output logic            sec_sq,
    output logic            scan_tick,
    output logic [IDX_W-1:0] scan_idx
);

    localparam logic [DIV_W-1:0] c_div_min  = DIV_W'(DIV_MIN);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NSCAN - 1);

    // ---------------------------------------------------------------- FSM
    state_t r_state;
    state_t w_state_nxt;
    logic   w_en;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        case (r_state)
            STOP: begin
                if (run) w_state_nxt = RUN;
            end
            RUN: begin
                w_en = 1'b1;
                if (!run) w_state_nxt = STOP;
            end
            default: w_state_nxt = STOP;
        endcase
    end

    // ------------------------------------------------------- config slot
    logic             r_pend_v;
    logic             r_pend_sel;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_div_clamp;
    logic             w_accept;
    logic             w_hit_sec;
    logic             w_hit_scan;
    logic             w_take_sec;
    logic             w_take_scan;

    always_comb begin
        w_div_clamp = (cfg.cfg_div < c_div_min) ? c_div_min : cfg.cfg_div;
        w_accept    = cfg.cfg_valid && !r_pend_v;
        w_hit_sec   = r_pend_v && (r_pend_sel == CH_SEC);
        w_hit_scan  = r_pend_v && (r_pend_sel == CH_SCAN);
    end

    assign cfg.cfg_ready = !r_pend_v;

    // A transfer needs an empty slot and an apply needs a full one, so the
    // two branches below can never both be wanted in the same cycle.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_pend_v   <= 1'b0;
            r_pend_sel <= CH_SEC;
            r_pend_div <= c_div_min;
        end else if (w_take_sec || w_take_scan) begin
            r_pend_v   <= 1'b0;
        end else if (w_accept) begin
            r_pend_v   <= 1'b1;
            r_pend_sel <= cfg.cfg_sel;
            r_pend_div <= w_div_clamp;
        end
    end

    // ----------------------------------------------------------- channels
    logic w_sec_fire;
    logic w_scan_fire;

    tick_chan #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (SEC_DIV_DEFAULT)
    ) u_sec (
        .clk        (clk),
        .RESET      (RESET),
        .i_en       (w_en),
        .i_sync     (sync_req),
        .i_pend_hit (w_hit_sec),
        .i_pend_div (r_pend_div),
        .o_tick     (sec_tick),
        .o_fire     (w_sec_fire),
        .o_take     (w_take_sec)
    );

    tick_chan #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (SCAN_DIV_DEFAULT)
    ) u_scan (
        .clk        (clk),
        .RESET      (RESET),
        .i_en       (w_en),
        .i_sync     (sync_req),
        .i_pend_hit (w_hit_scan),
        .i_pend_div (r_pend_div),
        .o_tick     (scan_tick),
        .o_fire     (w_scan_fire),
        .o_take     (w_take_scan)
    );

    // ------------------------------------------- blink level / digit index
    // Both update on the same edge that raises the matching tick, so the
    // new value is visible while the tick is high.
    logic             r_sq;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_sq  <= 1'b0;
            r_idx <= '0;
        end else if (sync_req) begin
            r_sq  <= 1'b0;
            r_idx <= '0;
        end else begin
            if (w_sec_fire) begin
                r_sq <= !r_sq;
            end
            if (w_scan_fire) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign sec_sq   = r_sq;
    assign scan_idx = r_idx;

endmodule : tick_sched
`default_nettype wire

// File: tb/tb_tick_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_sched
//  Description : Self-checking bench for tick_sched (SEC=10, SCAN=3, NSCAN=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_sched;

    localparam int DIV_W = 8;
    localparam int SEC_D = 10;
    localparam int SCAN_D = 3;
    localparam int NSCAN = 4;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       run = 1'b0;
    logic       sync_req = 1'b0;
    logic       sec_tick, sec_sq, scan_tick;
    logic [1:0] scan_idx;

    tick_sched_if #(.DIV_W(DIV_W)) cfg_if ();

    tick_sched #(
        .DIV_W            (DIV_W),
        .SEC_DIV_DEFAULT  (SEC_D),
        .SCAN_DIV_DEFAULT (SCAN_D),
        .NSCAN            (NSCAN)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .run       (run),
        .sync_req  (sync_req),
        .cfg       (cfg_if),
        .sec_tick  (sec_tick),
        .sec_sq    (sec_sq),
        .scan_tick (scan_tick),
        .scan_idx  (scan_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model: elapsed cycles within each period
    bit m_run;
    int m_el [2];
    int m_per [2];
    bit m_pv;
    bit m_ps;
    int m_pd;
    bit m_sq;
    int m_idx;
    bit m_tk [2];

    function automatic void model_reset();
        m_run = 0; m_el[0] = 0; m_el[1] = 0;
        m_per[0] = SEC_D; m_per[1] = SCAN_D;
        m_pv = 0; m_ps = 0; m_pd = 2;
        m_sq = 0; m_idx = 0; m_tk[0] = 0; m_tk[1] = 0;
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    function automatic void model_edge();
        bit fire [2];
        bit take = 0;
        bit accept = cfg_if.cfg_valid && !m_pv;
        for (int ch = 0; ch < 2; ch++) begin
            bit hit = m_pv && (int'(m_ps) == ch);
            fire[ch] = 0;
            if (sync_req) begin
                if (hit) begin m_per[ch] = m_pd; take = 1; end
                m_el[ch] = 0;
            end else if (m_run) begin
                if (m_el[ch] + 1 >= m_per[ch]) begin
                    fire[ch] = 1; m_el[ch] = 0;
                    if (hit) begin m_per[ch] = m_pd; take = 1; end
                end else begin
                    m_el[ch]++;
                end
            end else if (hit) begin
                m_per[ch] = m_pd; m_el[ch] = 0; take = 1;
            end
        end
        if (take) m_pv = 0;
        if (accept) begin
            m_pv = 1; m_ps = cfg_if.cfg_sel;
            m_pd = (int'(cfg_if.cfg_div) < 2) ? 2 : int'(cfg_if.cfg_div);
        end
        if (sync_req) begin
            m_sq = 0; m_idx = 0;
        end else begin
            if (fire[0]) m_sq = !m_sq;
            if (fire[1]) m_idx = (m_idx + 1) % NSCAN;
        end
        m_tk[0] = fire[0]; m_tk[1] = fire[1];
        m_run = run;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("sec_tick",  int'(sec_tick),  int'(m_tk[0]));
        chk("scan_tick", int'(scan_tick), int'(m_tk[1]));
        chk("sec_sq",    int'(sec_sq),    int'(m_sq));
        chk("scan_idx",  int'(scan_idx),  m_idx);
        chk("cfg_ready", int'(cfg_if.cfg_ready), int'(!m_pv));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        chk("rst sec_tick",  int'(sec_tick), 0);
        chk("rst scan_tick", int'(scan_tick), 0);
        chk("rst sec_sq",    int'(sec_sq), 0);
        chk("rst scan_idx",  int'(scan_idx), 0);
        chk("rst cfg_ready", int'(cfg_if.cfg_ready), 1);
        #1;
        RESET = 1'b0;
    endtask

    // Step until the chosen tick (0 = sec, 1 = scan) is seen; n = edges used.
    task automatic wait_tick(input int which, input int bound, output int n);
        logic seen;
        n = 0;
        do begin
            step();
            n++;
            seen = (which == 0) ? sec_tick : scan_tick;
        end while (seen !== 1'b1 && n < bound);
        if (seen !== 1'b1) begin
            n_chk++; n_err++;
            $display("FAIL wait_tick%0d: none within %0d cycles, expected one", which, bound);
        end
    endtask

    typedef struct {
        bit run;
        bit sec;
        bit scan;
        int idx;
        bit sq;
    } vec_t;

    vec_t tbl [14];
    int   n;

    initial begin
        // Edge-by-edge expectations after reset release with run=1.
        tbl = '{'{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,1,1,0},
                '{1,0,0,1,0}, '{1,0,0,1,0}, '{1,0,1,2,0}, '{1,0,0,2,0},
                '{1,0,0,2,0}, '{1,0,1,3,0}, '{1,1,0,3,1}, '{1,0,0,3,1},
                '{1,0,1,0,1}, '{1,0,0,0,1}};

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_sel   = 1'b0;
        cfg_if.cfg_div   = '0;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            run = tbl[i].run;
            step();
            chk($sformatf("tbl%0d sec_tick", i),  int'(sec_tick),  int'(tbl[i].sec));
            chk($sformatf("tbl%0d scan_tick", i), int'(scan_tick), int'(tbl[i].scan));
            chk($sformatf("tbl%0d scan_idx", i),  int'(scan_idx),  tbl[i].idx);
            chk($sformatf("tbl%0d sec_sq", i),    int'(sec_sq),    int'(tbl[i].sq));
        end

        // Reset mid-count, then first tick 10 RUN cycles after release.
        do_reset();
        wait_tick(0, 40, n);
        chk("first sec after reset", n, 11);

        // Hold for 5 cycles mid-period: remaining count resumes.
        repeat (3) step();
        run = 1'b0;
        repeat (5) step();
        run = 1'b1;
        wait_tick(0, 40, n);
        chk("sec after hold", n, 7);

        // Reprogram seconds divisor to 4 while running.
        repeat (2) step();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b0; cfg_if.cfg_div = 8'd4;
        step();
        chk("ready after cfg", int'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_sel = 1'b1; cfg_if.cfg_div = 8'd5;
        step();
        cfg_if.cfg_valid = 1'b0;
        wait_tick(0, 40, n);
        chk("old period completes", n, 6);
        chk("ready after apply", int'(cfg_if.cfg_ready), 1);
        wait_tick(0, 40, n);
        chk("new sec period a", n, 4);
        wait_tick(0, 40, n);
        chk("new sec period b", n, 4);

        // Scan divisor 0 and 1 both clamp to 2.
        for (int d = 0; d < 2; d++) begin
            cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b1; cfg_if.cfg_div = 8'(d);
            step();
            cfg_if.cfg_valid = 1'b0;
            n = 0;
            while (cfg_if.cfg_ready !== 1'b1 && n < 40) begin step(); n++; end
            chk("scan cfg applied", int'(cfg_if.cfg_ready), 1);
            wait_tick(1, 40, n);
            wait_tick(1, 40, n);
            chk($sformatf("scan period div%0d", d), n, 2);
        end

        // sync on the sec terminal count.
        do_reset();
        wait_tick(0, 40, n);
        repeat (9) step();
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        chk("sync sec_tick", int'(sec_tick), 0);
        chk("sync scan_idx", int'(scan_idx), 0);
        chk("sync sec_sq", int'(sec_sq), 0);
        wait_tick(0, 40, n);
        chk("sec after sync", n, 10);

        // sync applies a pending divisor immediately.
        repeat (2) step();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b0; cfg_if.cfg_div = 8'd6;
        step();
        cfg_if.cfg_valid = 1'b0;
        step();
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        chk("ready after sync apply", int'(cfg_if.cfg_ready), 1);
        wait_tick(0, 40, n);
        chk("sync pending period a", n, 6);
        wait_tick(0, 40, n);
        chk("sync pending period b", n, 6);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            run              = ($urandom_range(0, 9) != 0);
            sync_req         = ($urandom_range(0, 49) == 0);
            cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_sel   = 1'($urandom_range(0, 1));
            cfg_if.cfg_div   = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end
        sync_req = 1'b0;
        cfg_if.cfg_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_tick_sched
`default_nettype wire
